// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART controllers.
// Used by uart_tx_sched and uart_baud_counter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam int UART_DATA_WIDTH   = 8;
   localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running bit-time counter with synchronous clear.
// bit_end marks the last cycle of a bit; bit_pre_end the cycle before it.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic bit_end,
   output logic bit_pre_end
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] r_count;
   logic          w_last;

   assign w_last      = (r_count == LAST);
   assign bit_end     = w_last;
   assign bit_pre_end = (r_count == PRE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clear || w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: drains the TX FIFO, one frame per entry, onto the tx line.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = UART_DATA_WIDTH,
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   input  logic                  tx_enable,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

   tx_state_t             r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [IW-1:0]         r_bit_idx;
   logic                  r_stop_cnt;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_rd_en;
   logic                  r_done;
`ifdef UART_TX_PARITY_EN
   logic                  r_par;
`endif

   logic                  w_clear;
   logic                  w_bit_end;
   logic                  w_pre_end;
   logic                  w_go;
   logic                  w_last_stop;
   logic [DATA_WIDTH-1:0] w_shift_nxt;

   assign w_go        = !fifo_empty && tx_enable;
   assign w_last_stop = (STOP_BITS == 1) || r_stop_cnt;
   assign w_shift_nxt = r_shift >> 1;

   // Every other state change lands on a bit_end wrap, so holding the
   // counter clear in IDLE/LOAD is enough to zero it on each state entry.
   assign w_clear = (r_state == IDLE) || (r_state == LOAD);

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk        (clk),
      .reset      (reset),
      .clear      (w_clear),
      .bit_end    (w_bit_end),
      .bit_pre_end(w_pre_end)
   );

   assign tx         = r_tx;
   assign busy       = r_busy;
   assign fifo_rd_en = r_rd_en;
   assign frame_done = r_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_rd_en    <= 1'b0;
         r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else begin
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (w_go) begin
                  r_state <= LOAD;
                  r_rd_en <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            LOAD: begin
               r_shift    <= fifo_rd_data;
               r_bit_idx  <= '0;
               r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
               r_par      <= 1'b0;
`endif
               r_tx       <= 1'b0;
               r_state    <= START;
            end
            START: begin
               if (w_bit_end) begin
                  r_state <= DATA;
                  r_tx    <= r_shift[0];
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_shift <= w_shift_nxt;
`ifdef UART_TX_PARITY_EN
                  r_par   <= r_par ^ r_shift[0];
`endif
                  if (r_bit_idx == LAST_IDX) begin
                     r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     r_state   <= PARITY;
                     r_tx      <= r_par ^ r_shift[0];
`else
                     r_state   <= STOP;
                     r_tx      <= 1'b1;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + IW'(1);
                     r_tx      <= w_shift_nxt[0];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_bit_end) begin
                  r_state <= STOP;
                  r_tx    <= 1'b1;
               end
            end
`endif
            STOP: begin
               if (w_pre_end && w_last_stop) begin
                  r_done <= 1'b1;
               end
               if (w_bit_end) begin
                  if (!w_last_stop) begin
                     r_stop_cnt <= 1'b1;
                  end else if (w_go) begin
                     r_state <= LOAD;
                     r_rd_en <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
